// File: rtl/eros_addr_map_unit.sv
// eros_addr_map_unit: runtime-programmable rule table decoding request addresses to a slave port
// index over a two-stage valid/ready pipeline. Optional miss tracking: EROS_ADDR_MAP_MISS_CNT_EN.
module eros_addr_map_unit #(
   parameter int NUM_RULES   = 5,
   parameter int NUM_PORTS   = 5,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEFAULT_IDX = 0,
   parameter int PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   parameter int RULE_W      = 2 * ADDR_WIDTH + PORT_W,
   // One {start, end, idx} slot per rule, rule 0 in the least significant slot
   parameter logic [NUM_RULES*RULE_W-1:0] RST_RULES = {
      32'hF002_8000, 32'hF003_0000, 3'd4,
      32'hF002_0000, 32'hF002_8000, 3'd3,
      32'h4000_0000, 32'h4100_0000, 3'd2,
      32'hF001_0000, 32'hF002_0000, 3'd1,
      32'h8000_0000, 32'hC000_0000, 3'd0}
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              req_valid_i,
   output logic                              req_ready_o,
   input  logic [ADDR_WIDTH-1:0]             req_addr_i,
   output logic                              rsp_valid_o,
   input  logic                              rsp_ready_i,
   output logic [PORT_W-1:0]                 rsp_idx_o,
   output logic                              rsp_hit_o,
   input  logic                              cfg_req_i,
   input  logic                              cfg_we_i,
   input  logic [$clog2(NUM_RULES+1)+1:0]    cfg_addr_i,
   input  logic [ADDR_WIDTH-1:0]             cfg_wdata_i,
   output logic [ADDR_WIDTH-1:0]             cfg_rdata_o,
   output logic                              cfg_err_o
);
   localparam int SEL_W = $clog2(NUM_RULES + 1);
   localparam logic [PORT_W-1:0] DEF_IDX = PORT_W'(DEFAULT_IDX);

   logic [ADDR_WIDTH-1:0] rule_start [NUM_RULES];
   logic [ADDR_WIDTH-1:0] rule_end   [NUM_RULES];
   logic [PORT_W-1:0]     rule_idx   [NUM_RULES];
   logic [NUM_RULES-1:0]  rule_en;
   logic                  lock;

   logic [SEL_W-1:0]      cfg_sel;
   logic [1:0]            cfg_fld;
   logic                  sel_rule, sel_glob;
   logic                  cfg_wr_ok, cfg_rd_ok, cfg_err_nxt;
   logic [ADDR_WIDTH-1:0] cfg_rd_val, miss_cnt_rd, miss_addr_rd;

   logic [NUM_RULES-1:0]  match, match_p1;
   logic                  vld_p1, vld_p2, adv_p1, adv_p2;
   logic [PORT_W-1:0]     enc_idx, idx_p2;
   logic                  enc_hit, hit_p2;

   assign cfg_sel  = cfg_addr_i[SEL_W+1:2];
   assign cfg_fld  = cfg_addr_i[1:0];
   assign sel_rule = 32'(cfg_sel) < 32'(NUM_RULES);
   assign sel_glob = 32'(cfg_sel) == 32'(NUM_RULES);

   always_comb begin
      cfg_wr_ok   = 1'b0;
      cfg_rd_ok   = 1'b0;
      cfg_err_nxt = 1'b0;
      cfg_rd_val  = '0;
      if (sel_rule) begin
         case (cfg_fld)
            2'd0:    cfg_rd_val = rule_start[cfg_sel];
            2'd1:    cfg_rd_val = rule_end[cfg_sel];
            2'd2:    cfg_rd_val = ADDR_WIDTH'(rule_idx[cfg_sel]);
            default: cfg_rd_val = ADDR_WIDTH'(rule_en[cfg_sel]);
         endcase
      end else begin
         case (cfg_fld)
            2'd0:    cfg_rd_val = ADDR_WIDTH'(lock);
            2'd1:    cfg_rd_val = miss_cnt_rd;
            2'd2:    cfg_rd_val = miss_addr_rd;
            default: cfg_rd_val = '0;
         endcase
      end
      if (cfg_req_i) begin
         if (sel_rule) begin
            if (!cfg_we_i)
               cfg_rd_ok = 1'b1;
            else if (lock || (cfg_fld == 2'd2 && cfg_wdata_i >= ADDR_WIDTH'(NUM_PORTS)))
               cfg_err_nxt = 1'b1;
            else
               cfg_wr_ok = 1'b1;
         end else if (sel_glob) begin
            if (!cfg_we_i)
               cfg_rd_ok = 1'b1;
            else if (cfg_fld == 2'd1 || cfg_fld == 2'd2)
               cfg_err_nxt = 1'b1;
         end else begin
            cfg_err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_RULES; r++) begin
            rule_start[r] <= RST_RULES[r*RULE_W + PORT_W + ADDR_WIDTH +: ADDR_WIDTH];
            rule_end[r]   <= RST_RULES[r*RULE_W + PORT_W +: ADDR_WIDTH];
            rule_idx[r]   <= RST_RULES[r*RULE_W +: PORT_W];
         end
         rule_en     <= '1;
         lock        <= 1'b0;
         cfg_rdata_o <= '0;
         cfg_err_o   <= 1'b0;
      end else begin
         if (cfg_wr_ok) begin
            case (cfg_fld)
               2'd0:    rule_start[cfg_sel] <= cfg_wdata_i;
               2'd1:    rule_end[cfg_sel]   <= cfg_wdata_i;
               2'd2:    rule_idx[cfg_sel]   <= cfg_wdata_i[PORT_W-1:0];
               default: rule_en[cfg_sel]    <= cfg_wdata_i[0];
            endcase
         end
         // Lock is set-only; only reset clears it
         if (cfg_req_i && cfg_we_i && sel_glob && cfg_fld == 2'd0 && cfg_wdata_i[0])
            lock <= 1'b1;
         if (cfg_rd_ok)
            cfg_rdata_o <= cfg_rd_val;
         cfg_err_o <= cfg_err_nxt;
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_RULES; r++)
         match[r] = rule_en[r] && (req_addr_i >= rule_start[r]) && (req_addr_i < rule_end[r]);
   end

   always_comb begin
      enc_idx = DEF_IDX;
      enc_hit = 1'b0;
      for (int r = NUM_RULES - 1; r >= 0; r--) begin
         if (match_p1[r]) begin
            enc_idx = rule_idx[r];
            enc_hit = 1'b1;
         end
      end
   end

   assign adv_p2      = !vld_p2 || rsp_ready_i;
   assign adv_p1      = !vld_p1 || adv_p2;
   assign req_ready_o = adv_p1;

   // Stage p1: per-rule match vector
   always_ff @(posedge clk_i) begin
      if (adv_p1 && req_valid_i)
         match_p1 <= match;
   end

   // Stage p2: priority-encoded result
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         idx_p2 <= '0;
         hit_p2 <= 1'b0;
      end else begin
         if (adv_p1)
            vld_p1 <= req_valid_i;
         if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               idx_p2 <= enc_idx;
               hit_p2 <= enc_hit;
            end
         end
      end
   end

   assign rsp_valid_o = vld_p2;
   assign rsp_idx_o   = idx_p2;
   assign rsp_hit_o   = hit_p2;

`ifdef EROS_ADDR_MAP_MISS_CNT_EN
   logic [ADDR_WIDTH-1:0] addr_p1, addr_p2, miss_addr;
   logic [31:0]           miss_cnt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (adv_p1 && req_valid_i)
         addr_p1 <= req_addr_i;
      if (adv_p2 && vld_p1)
         addr_p2 <= addr_p1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         miss_cnt  <= '0;
         miss_addr <= '0;
      end else if (vld_p2 && rsp_ready_i && !hit_p2) begin
         miss_cnt  <= sat_inc(miss_cnt);
         miss_addr <= addr_p2;
      end
   end

   assign miss_cnt_rd  = ADDR_WIDTH'(miss_cnt);
   assign miss_addr_rd = miss_addr;
`else
   assign miss_cnt_rd  = '0;
   assign miss_addr_rd = '0;
`endif
endmodule
